// File: rtl/input_cond_pkg.sv
// rtl/input_cond_pkg.sv - shared types and width helper for the arcade input conditioner
package input_cond_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } coin_state_t;

    function automatic int cnt_w(input int max);
        return $clog2(max + 1);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - 2-FF synchroniser plus stable-count debouncer for one raw control
module debounce_bit
    import input_cond_pkg::*;
#(
    parameter int DEB_CYCLES = 20000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level
);

    localparam int DW = cnt_w(DEB_CYCLES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_level;
    logic [DW-1:0] r_cnt;

    // Any cycle where the synced input agrees with the accepted level restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1 <= raw;
            r_s2 <= r_s1;
            if (r_s2 != r_level) begin
                if (r_cnt == DEB_LAST) begin
                    r_level <= ~r_level;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign level = r_level;

endmodule

// File: rtl/arcade_input_cond.sv
// rtl/arcade_input_cond.sv - debounced buttons, queued coin pulse shaper, optional autofire (AUTOFIRE_EN)
module arcade_input_cond
    import input_cond_pkg::*;
#(
    parameter int N_BTN      = 8,
    parameter int DEB_CYCLES = 20000,
    parameter int COIN_PULSE = 2000000,
    parameter int COIN_GAP   = 2000000,
    parameter int COIN_QUEUE = 3,
    parameter int AF_HALF    = 1000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_BTN-1:0] btn_in,
    input  logic [1:0]       fire_in,
    input  logic             coin_in,
    input  logic             pause,
    input  logic [1:0]       af_enable,
    output logic [N_BTN-1:0] btn_out,
    output logic [1:0]       fire_out,
    output logic             coin_out,
    output logic [1:0]       coin_pending,
    output logic             coin_drop
);

    localparam int NB = N_BTN + 3;
    localparam int PW = cnt_w(COIN_PULSE);
    localparam int GW = cnt_w(COIN_GAP);
    localparam int CW = (PW > GW) ? PW : GW;
    localparam logic [CW-1:0] PULSE_LAST = CW'(COIN_PULSE - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(COIN_GAP - 1);
    localparam logic [1:0]    QMAX       = 2'(COIN_QUEUE);

    logic [NB-1:0] w_raw;
    logic [NB-1:0] w_level;
    logic [1:0]    w_fire;
    logic          w_coin_lvl;

    assign w_raw = {coin_in, fire_in, btn_in};

    for (genvar g = 0; g < NB; g++) begin : g_deb
        debounce_bit #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk    (clk),
            .reset_n(reset_n),
            .raw    (w_raw[g]),
            .level  (w_level[g])
        );
    end

    assign btn_out    = w_level[N_BTN-1:0];
    assign w_fire     = w_level[N_BTN+1:N_BTN];
    assign w_coin_lvl = w_level[N_BTN+2];

    coin_state_t   r_state;
    coin_state_t   w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [1:0]    r_pend;
    logic          r_coin_prev;
    logic          r_drop;
    logic          w_rise;
    logic          w_deq;

    assign w_rise = w_coin_lvl & ~r_coin_prev;
    assign w_deq  = (r_state == IDLE) && (r_pend != 2'd0) && !pause;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_deq) begin
                    w_state_nxt = PULSE;
                    w_cnt_nxt   = '0;
                end
            end
            PULSE: begin
                if (r_cnt == PULSE_LAST) begin
                    w_state_nxt = GAP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // A coin edge coinciding with a dequeue cancels out instead of counting as a drop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend      <= 2'd0;
            r_coin_prev <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            r_coin_prev <= w_coin_lvl;
            r_drop      <= w_rise && !w_deq && (r_pend == QMAX);
            if (w_rise && !w_deq && (r_pend != QMAX)) begin
                r_pend <= r_pend + 2'd1;
            end else if (w_deq && !w_rise) begin
                r_pend <= r_pend - 2'd1;
            end
        end
    end

    assign coin_out     = (r_state == PULSE);
    assign coin_pending = r_pend;
    assign coin_drop    = r_drop;

`ifdef AUTOFIRE_EN
    localparam int AW = cnt_w(AF_HALF);
    localparam logic [AW-1:0] AF_LAST = AW'(AF_HALF - 1);

    logic [AW-1:0] r_af_cnt [2];
    logic [1:0]    r_af_ph;

    // Phase 0 means "output high", so a fresh press always starts with fire asserted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                r_af_cnt[i] <= '0;
                r_af_ph[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_fire[i] && af_enable[i]) begin
                    if (r_af_cnt[i] == AF_LAST) begin
                        r_af_cnt[i] <= '0;
                        r_af_ph[i]  <= ~r_af_ph[i];
                    end else begin
                        r_af_cnt[i] <= r_af_cnt[i] + 1'b1;
                    end
                end else begin
                    r_af_cnt[i] <= '0;
                    r_af_ph[i]  <= 1'b0;
                end
            end
        end
    end

    assign fire_out = w_fire & ~(af_enable & r_af_ph);
`else
    logic w_unused_af;

    assign w_unused_af = ^{af_enable, AF_HALF[0]};
    assign fire_out    = w_fire;
`endif

endmodule

// File: tb/tb_arcade_input_cond.sv
// tb/tb_arcade_input_cond.sv - randomized and directed bench with a behavioural reference model
module tb_arcade_input_cond;

    localparam int N_BTN = 8;
    localparam int DEB   = 4;
    localparam int PUL   = 6;
    localparam int GAPC  = 5;
    localparam int QD    = 3;
    localparam int AFH   = 3;
    localparam int NB    = N_BTN + 3;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [N_BTN-1:0] btn_in = '0;
    logic [1:0]       fire_in = '0;
    logic             coin_in = 1'b0;
    logic             pause = 1'b0;
    logic [1:0]       af_enable = '0;
    logic [N_BTN-1:0] btn_out;
    logic [1:0]       fire_out;
    logic             coin_out;
    logic [1:0]       coin_pending;
    logic             coin_drop;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    arcade_input_cond #(
        .N_BTN(N_BTN), .DEB_CYCLES(DEB), .COIN_PULSE(PUL),
        .COIN_GAP(GAPC), .COIN_QUEUE(QD), .AF_HALF(AFH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .btn_in(btn_in), .fire_in(fire_in),
        .coin_in(coin_in), .pause(pause), .af_enable(af_enable),
        .btn_out(btn_out), .fire_out(fire_out), .coin_out(coin_out),
        .coin_pending(coin_pending), .coin_drop(coin_drop)
    );

    logic [N_BTN+5:0] dut_vec;
    assign dut_vec = {btn_out, fire_out, coin_out, coin_pending, coin_drop};

    // Reference model: inputs seen two edges late, a level accepted after DEB disagreeing cycles,
    // coins as an integer count served on a time schedule, autofire phase from elapsed time.
    int            cyc = 0;
    logic [NB-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0;
    logic [NB-1:0] w_raw;
    int            m_run [NB];
    int            m_t0 [2] = '{-1, -1};
    int            m_pend = 0, m_start = -1000, m_free = 0;
    bit            m_prev = 1'b0, m_drop = 1'b0, m_deq, m_rise;

    assign w_raw = {coin_in, fire_in, btn_in};

    initial begin
        for (int i = 0; i < NB; i++) m_run[i] = 0;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_s1 = '0; m_s2 = '0; m_lvl = '0; m_prev = 1'b0; m_drop = 1'b0;
                m_pend = 0; m_start = -1000; m_free = 0; m_t0[0] = -1; m_t0[1] = -1;
                for (int i = 0; i < NB; i++) m_run[i] = 0;
            end else begin
                cyc++;
                m_deq  = (cyc >= m_free) && (m_pend > 0) && !pause;
                m_rise = m_lvl[NB-1] && !m_prev;
                m_drop = m_rise && !m_deq && (m_pend == QD);
                if (m_rise && !m_deq && m_pend < QD) m_pend++;
                else if (m_deq && !m_rise) m_pend--;
                if (m_deq) begin
                    m_start = cyc;
                    m_free  = cyc + PUL + GAPC + 1;
                end
                m_prev = m_lvl[NB-1];
                for (int i = 0; i < 2; i++) begin
                    if (m_lvl[N_BTN+i] && af_enable[i]) begin
                        if (m_t0[i] < 0) m_t0[i] = cyc - 1;
                    end else begin
                        m_t0[i] = -1;
                    end
                end
                for (int i = 0; i < NB; i++) begin
                    if (m_s2[i] != m_lvl[i]) m_run[i]++;
                    else m_run[i] = 0;
                    if (m_run[i] == DEB) begin
                        m_lvl[i] = ~m_lvl[i];
                        m_run[i] = 0;
                    end
                end
                m_s2 = m_s1;
                m_s1 = w_raw;
            end
        end
    end

    function automatic logic [N_BTN+5:0] exp_vec();
        logic [1:0] f;
        for (int i = 0; i < 2; i++) begin
`ifdef AUTOFIRE_EN
            f[i] = m_lvl[N_BTN+i] & ~(af_enable[i] & (m_t0[i] >= 0) &
                   ((((cyc - m_t0[i]) / AFH) % 2) == 1));
`else
            f[i] = m_lvl[N_BTN+i];
`endif
        end
        return {m_lvl[N_BTN-1:0], f, ((cyc - m_start) < PUL), 2'(m_pend), m_drop};
    endfunction

    int   q_rise[$];
    int   q_width[$];
    int   drop_cnt = 0;
    int   run_len = 0;
    logic mon_prev = 1'b0;

    initial forever begin
        @(negedge clk);
        if (coin_drop) drop_cnt++;
        if (coin_out && !mon_prev) begin
            q_rise.push_back(cyc);
            run_len = 0;
        end
        if (coin_out) run_len++;
        else if (mon_prev) q_width.push_back(run_len);
        mon_prev = coin_out;
    end

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (dut_vec !== '0) $display("FAIL reset_outputs: got %h want 0", dut_vec);
        else pass_cnt++;
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        total_cnt++;
        if (dut_vec !== '0) $display("FAIL idle_after_reset: got %h want 0", dut_vec);
        else pass_cnt++;
    endtask

    task automatic test_debounce();
        bit glitch = 1'b0;
        int n = -1;
        btn_in[0] = 1'b1;
        repeat (3) @(negedge clk);
        btn_in[0] = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (btn_out[0]) glitch = 1'b1;
        end
        total_cnt++;
        if (glitch) $display("FAIL deb_glitch: got btn_out[0]=1 want 0");
        else pass_cnt++;
        btn_in[0] = 1'b1;
        for (int k = 1; k <= 30 && n < 0; k++) begin
            @(negedge clk);
            if (btn_out[0]) n = k;
        end
        total_cnt++;
        if (n != DEB + 2) $display("FAIL deb_latency: got %0d want %0d", n, DEB + 2);
        else pass_cnt++;
        repeat (14) @(negedge clk);
        total_cnt++;
        if (dut_vec !== exp_vec()) $display("FAIL deb_hold: got %h want %h", dut_vec, exp_vec());
        else pass_cnt++;
        btn_in[0] = 1'b0;
        repeat (8) @(negedge clk);
        total_cnt++;
        if (btn_out[0] !== 1'b0) $display("FAIL deb_release: got %b want 0", btn_out[0]);
        else pass_cnt++;
    endtask

    task automatic test_coin_single();
        int w;
        q_rise.delete();
        q_width.delete();
        coin_in = 1'b1;
        repeat (10) @(negedge clk);
        coin_in = 1'b0;
        repeat (30) @(negedge clk);
        w = (q_width.size() == 1) ? q_width[0] : -1;
        total_cnt++;
        if (q_rise.size() != 1) $display("FAIL coin_single_count: got %0d want 1", q_rise.size());
        else pass_cnt++;
        total_cnt++;
        if (w != PUL) $display("FAIL coin_single_width: got %0d want %0d", w, PUL);
        else pass_cnt++;
        total_cnt++;
        if ({coin_out, coin_pending} !== 3'b000) $display("FAIL coin_single_idle: got %b want 000", {coin_out, coin_pending});
        else pass_cnt++;
    endtask

    task automatic test_queue_pause();
        pause = 1'b1;
        drop_cnt = 0;
        q_rise.delete();
        q_width.delete();
        for (int k = 0; k < 4; k++) begin
            coin_in = 1'b1;
            repeat (7) @(negedge clk);
            coin_in = 1'b0;
            repeat (7) @(negedge clk);
            if (k == 1) begin
                total_cnt++;
                if ({coin_out, coin_pending} !== 3'b010) $display("FAIL pause_two: got %b want 010", {coin_out, coin_pending});
                else pass_cnt++;
            end
        end
        repeat (4) @(negedge clk);
        total_cnt++;
        if (drop_cnt != 1) $display("FAIL queue_drop: got %0d want 1", drop_cnt);
        else pass_cnt++;
        total_cnt++;
        if ({coin_out, coin_pending} !== 3'b011 || q_rise.size() != 0) $display("FAIL queue_full: got %b rises %0d want 011 rises 0", {coin_out, coin_pending}, q_rise.size());
        else pass_cnt++;
        pause = 1'b0;
        repeat (50) @(negedge clk);
        total_cnt++;
        if (q_rise.size() != 3) $display("FAIL queue_pulses: got %0d want 3", q_rise.size());
        else pass_cnt++;
        for (int k = 1; k < q_rise.size(); k++) begin
            total_cnt++;
            if (q_rise[k] - q_rise[k-1] != PUL + GAPC + 1) $display("FAIL queue_spacing%0d: got %0d want %0d", k, q_rise[k] - q_rise[k-1], PUL + GAPC + 1);
            else pass_cnt++;
        end
        for (int k = 0; k < q_width.size(); k++) begin
            total_cnt++;
            if (q_width[k] != PUL) $display("FAIL queue_width%0d: got %0d want %0d", k, q_width[k], PUL);
            else pass_cnt++;
        end
        total_cnt++;
        if (coin_pending !== 2'd0) $display("FAIL queue_drained: got %0d want 0", coin_pending);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_pulse();
        int t = 0;
        btn_in[1] = 1'b1;
        pause = 1'b1;
        for (int k = 0; k < 2; k++) begin
            coin_in = 1'b1;
            repeat (7) @(negedge clk);
            coin_in = 1'b0;
            repeat (7) @(negedge clk);
        end
        pause = 1'b0;
        while (!coin_out && t < 20) begin
            @(negedge clk);
            t++;
        end
        total_cnt++;
        if (!coin_out) $display("FAIL midpulse_start: got coin_out=0 after %0d cycles want 1", t);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({btn_out[1], coin_out, coin_pending} !== 4'b1101) $display("FAIL midpulse_pre: got %b want 1101", {btn_out[1], coin_out, coin_pending});
        else pass_cnt++;
        #2 reset_n = 1'b0;
        #1;
        total_cnt++;
        if ({btn_out, coin_out, coin_pending} !== '0) $display("FAIL midpulse_reset: got %h want 0", {btn_out, coin_out, coin_pending});
        else pass_cnt++;
        btn_in = '0;
        @(negedge clk);
        reset_n = 1'b1;
        q_rise.delete();
        q_width.delete();
        repeat (40) @(negedge clk);
        total_cnt++;
        if (q_rise.size() != 0 || coin_pending !== 2'd0) $display("FAIL midpulse_lost: got rises %0d pend %0d want 0 0", q_rise.size(), coin_pending);
        else pass_cnt++;
    endtask

    task automatic test_fire();
        logic [11:0] got0, got1, want0;
        int t = 0;
        af_enable = 2'b01;
        fire_in = 2'b11;
        while (!fire_out[1] && t < 20) begin
            @(negedge clk);
            t++;
        end
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            got0[k] = fire_out[0];
            got1[k] = fire_out[1];
`ifdef AUTOFIRE_EN
            want0[k] = (((k / AFH) % 2) == 0);
`else
            want0[k] = 1'b1;
`endif
        end
        total_cnt++;
        if (got0 !== want0) $display("FAIL fire0_pattern: got %b want %b", got0, want0);
        else pass_cnt++;
        total_cnt++;
        if (got1 !== 12'hfff) $display("FAIL fire1_steady: got %b want %b", got1, 12'hfff);
        else pass_cnt++;
        fire_in = 2'b00;
        repeat (8) @(negedge clk);
        total_cnt++;
        if (fire_out !== 2'b00) $display("FAIL fire_release: got %b want 00", fire_out);
        else pass_cnt++;
        af_enable = 2'b00;
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            total_cnt++;
            if (dut_vec !== exp_vec()) $display("FAIL rand_cycle%0d: got %h want %h", c, dut_vec, exp_vec());
            else pass_cnt++;
            if ($urandom_range(0, 3) == 0) btn_in = btn_in ^ N_BTN'(1 << $urandom_range(0, N_BTN - 1));
            if ($urandom_range(0, 4) == 0) fire_in = fire_in ^ 2'($urandom_range(1, 3));
            if ($urandom_range(0, 5) == 0) coin_in = ~coin_in;
            if ($urandom_range(0, 39) == 0) pause = ~pause;
            if ($urandom_range(0, 49) == 0) af_enable = 2'($urandom_range(0, 3));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_debounce();
        test_coin_single();
        test_queue_pause();
        test_reset_mid_pulse();
        test_fire();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
